// File: rtl/time_set_ctrl.sv
// Alarm-clock core: time-of-day and alarm registers, button-driven set FSM, ring control.
// Optional snooze is built when the SNOOZE_EN macro is defined.
module time_set_ctrl #(
  parameter int SEC_MAX     = 60,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int AL_H_RST    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       alarm_en,
  output logic [4:0] H,
  output logic [5:0] M,
  output logic [5:0] S,
  output logic [4:0] AH,
  output logic [5:0] AM,
  output logic [2:0] state,
  output logic       blink,
  output logic       ring
);
  localparam int RCW = $clog2(RING_SECS + 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           mode_q, inc_q;
  logic           mode_press, inc_press;
  logic           s_wrap, m_wrap, run_tick, leave_set_m, alarm_hit;
  logic [5:0]     s_n, m_n;
  logic [4:0]     h_n;
  logic [RCW-1:0] ring_cnt;

  if (SEC_MAX < 2 || SEC_MAX > 64 || RING_SECS < 1 || SNOOZE_SECS < 1 ||
      AL_H_RST < 0 || AL_H_RST > 23) begin : g_param_check
    $error("time_set_ctrl: illegal parameter value");
  end

  assign mode_press  = mode_btn & ~mode_q;
  assign inc_press   = inc_btn & ~inc_q;
  assign run_tick    = sec_tick && (state_q == RUN);
  assign leave_set_m = mode_press && (state_q == SET_M);

  // Time the running clock would show after this tick; also feeds the alarm compare.
  assign s_wrap = (S == 6'(SEC_MAX - 1));
  assign m_wrap = (M == 6'd59);
  assign s_n    = s_wrap ? 6'd0 : S + 6'd1;
  assign m_n    = s_wrap ? (m_wrap ? 6'd0 : M + 6'd1) : M;
  assign h_n    = (s_wrap && m_wrap) ? ((H == 5'd23) ? 5'd0 : H + 5'd1) : H;

  assign alarm_hit = run_tick && alarm_en && (h_n == AH) && (m_n == AM) && (s_n == 6'd0);

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_AH;
        SET_AH:  state_d = SET_AM;
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      H      <= 5'd0;
      M      <= 6'd0;
      S      <= 6'd0;
      AH     <= 5'(AL_H_RST);
      AM     <= 6'd0;
      blink  <= 1'b0;
    end else begin
      mode_q <= mode_btn;
      inc_q  <= inc_btn;

      case (state_q)
        RUN: begin
          if (sec_tick) begin
            S <= s_n;
            M <= m_n;
            H <= h_n;
          end
        end
        SET_H:  if (inc_press && !mode_press) H <= (H == 5'd23) ? 5'd0 : H + 5'd1;
        SET_M: begin
          if (mode_press)     S <= 6'd0;
          else if (inc_press) M <= (M == 6'd59) ? 6'd0 : M + 6'd1;
        end
        SET_AH: if (inc_press && !mode_press) AH <= (AH == 5'd23) ? 5'd0 : AH + 5'd1;
        SET_AM: if (inc_press && !mode_press) AM <= (AM == 6'd59) ? 6'd0 : AM + 6'd1;
        default: ;
      endcase

      // A tick landing on the exit from SET_M is swallowed entirely.
      if (state_d == RUN)
        blink <= 1'b0;
      else if (sec_tick && (state_q != RUN) && !leave_set_m)
        blink <= ~blink;
    end
  end

`ifdef SNOOZE_EN
  localparam int SCW = $clog2(SNOOZE_SECS + 1);
  logic [SCW-1:0] snooze_cnt;
  logic           snooze_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring        <= 1'b0;
      ring_cnt    <= '0;
      snooze_cnt  <= '0;
      snooze_pend <= 1'b0;
    end else if (mode_press || !alarm_en) begin
      ring        <= 1'b0;
      ring_cnt    <= '0;
      snooze_cnt  <= '0;
      snooze_pend <= 1'b0;
    end else if (ring && inc_press) begin
      ring        <= 1'b0;
      ring_cnt    <= '0;
      snooze_cnt  <= SCW'(SNOOZE_SECS);
      snooze_pend <= 1'b1;
    end else if (alarm_hit) begin
      ring     <= 1'b1;
      ring_cnt <= RCW'(RING_SECS);
    end else begin
      if (ring && sec_tick) begin
        if (ring_cnt == RCW'(1)) ring <= 1'b0;
        ring_cnt <= ring_cnt - RCW'(1);
      end
      if (snooze_pend && run_tick) begin
        if (snooze_cnt == SCW'(1)) begin
          snooze_pend <= 1'b0;
          ring        <= 1'b1;
          ring_cnt    <= RCW'(RING_SECS);
        end
        snooze_cnt <= snooze_cnt - SCW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if (mode_press || !alarm_en || (ring && inc_press)) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if (alarm_hit) begin
      ring     <= 1'b1;
      ring_cnt <= RCW'(RING_SECS);
    end else if (ring && sec_tick) begin
      if (ring_cnt == RCW'(1)) ring <= 1'b0;
      ring_cnt <= ring_cnt - RCW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with SEC_MAX=4, RING_SECS=3, SNOOZE_SECS=5.
module tb_time_set_ctrl;
  logic       clk = 1'b0;
  logic       rst, sec_tick, mode_btn, inc_btn, alarm_en;
  logic [4:0] H, AH;
  logic [5:0] M, S, AM;
  logic [2:0] state;
  logic       blink, ring;

  int n_checks = 0;
  int n_fail   = 0;

  time_set_ctrl #(.SEC_MAX(4), .RING_SECS(3), .SNOOZE_SECS(5), .AL_H_RST(6)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .alarm_en(alarm_en), .H(H), .M(M), .S(S), .AH(AH), .AM(AM), .state(state),
    .blink(blink), .ring(ring)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: inputs change on negedge, results are read on the following negedge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) sec_tick = 1'b1;
      @(negedge clk) sec_tick = 1'b0;
    end
  endtask

  task automatic mode_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) mode_btn = 1'b1;
      @(negedge clk) mode_btn = 1'b0;
    end
  endtask

  task automatic inc_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) inc_btn = 1'b1;
      @(negedge clk) inc_btn = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if ({H, M, S} !== 17'd0) begin n_fail++; $display("FAIL reset_time: got %h required 0", {H, M, S}); end
    n_checks++; if ({AH, AM} !== {5'd6, 6'd0}) begin n_fail++; $display("FAIL reset_alarm: got AH=%0d AM=%0d required 6/0", AH, AM); end
    n_checks++; if ({state, blink, ring} !== 5'd0) begin n_fail++; $display("FAIL reset_ctrl: got state=%0d blink=%b ring=%b required 0/0/0", state, blink, ring); end
    @(negedge clk) rst = 1'b0;
    tick_n(3);
    n_checks++; if ({H, M, S} !== {5'd0, 6'd0, 6'd3}) begin n_fail++; $display("FAIL three_ticks: got %0d:%0d:%0d required 0:0:3", H, M, S); end
    n_checks++; if ({state, ring} !== 4'd0) begin n_fail++; $display("FAIL three_ticks_ctrl: got state=%0d ring=%b required 0/0", state, ring); end
  endtask

  task automatic test_preload_rollover;
    mode_n(1); inc_n(23);
    mode_n(1); inc_n(59);
    mode_n(1);
    n_checks++; if ({state, S} !== {3'd3, 6'd0}) begin n_fail++; $display("FAIL leave_set_m: got state=%0d S=%0d required 3/0", state, S); end
    mode_n(2);
    n_checks++; if ({state, H, M, S} !== {3'd0, 5'd23, 6'd59, 6'd0}) begin n_fail++; $display("FAIL preload: got st=%0d %0d:%0d:%0d required 0 23:59:0", state, H, M, S); end
    tick_n(3);
    n_checks++; if ({H, M, S} !== {5'd23, 6'd59, 6'd3}) begin n_fail++; $display("FAIL pre_rollover: got %0d:%0d:%0d required 23:59:3", H, M, S); end
    tick_n(1);
    n_checks++; if ({H, M, S} !== 17'd0) begin n_fail++; $display("FAIL day_rollover: got %0d:%0d:%0d required 0:0:0", H, M, S); end
  endtask

  task automatic test_set_fields;
    tick_n(1);
    mode_n(1); inc_n(25);
    n_checks++; if ({H, M, S} !== {5'd1, 6'd0, 6'd1}) begin n_fail++; $display("FAIL hour_wrap: got %0d:%0d:%0d required 1:0:1", H, M, S); end
    tick_n(1);
    n_checks++; if ({blink, S} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL blink_on: got blink=%b S=%0d required 1/1", blink, S); end
    tick_n(1);
    n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL blink_off: got %b required 0", blink); end
    @(negedge clk) begin mode_btn = 1'b1; inc_btn = 1'b1; end
    @(negedge clk) begin mode_btn = 1'b0; inc_btn = 1'b0; end
    n_checks++; if ({state, H, M} !== {3'd2, 5'd1, 6'd0}) begin n_fail++; $display("FAIL mode_wins: got st=%0d H=%0d M=%0d required 2/1/0", state, H, M); end
    @(negedge clk) begin mode_btn = 1'b1; sec_tick = 1'b1; end
    @(negedge clk) begin mode_btn = 1'b0; sec_tick = 1'b0; end
    n_checks++; if ({state, S, M} !== {3'd3, 6'd0, 6'd0}) begin n_fail++; $display("FAIL tick_on_exit: got st=%0d S=%0d M=%0d required 3/0/0", state, S, M); end
    mode_n(2);
    n_checks++; if ({state, blink} !== 4'd0) begin n_fail++; $display("FAIL back_to_run: got st=%0d blink=%b required 0/0", state, blink); end
  endtask

  task automatic test_alarm_ring;
    mode_n(1); inc_n(23);
    mode_n(2); inc_n(18);
    mode_n(1); inc_n(1);
    mode_n(1);
    n_checks++; if ({H, M, S, AH, AM} !== {5'd0, 6'd0, 6'd0, 5'd0, 6'd1}) begin n_fail++; $display("FAIL alarm_setup: got %0d:%0d:%0d AH=%0d AM=%0d required 0:0:0 0/1", H, M, S, AH, AM); end
    alarm_en = 1'b1;
    tick_n(3);
    n_checks++; if (ring !== 1'b0) begin n_fail++; $display("FAIL ring_early: got %b required 0", ring); end
    tick_n(1);
    n_checks++; if ({ring, M, S} !== {1'b1, 6'd1, 6'd0}) begin n_fail++; $display("FAIL ring_rise: got ring=%b M=%0d S=%0d required 1/1/0", ring, M, S); end
    tick_n(2);
    n_checks++; if (ring !== 1'b1) begin n_fail++; $display("FAIL ring_hold: got %b required 1", ring); end
    tick_n(1);
    n_checks++; if (ring !== 1'b0) begin n_fail++; $display("FAIL ring_timeout: got %b required 0", ring); end
  endtask

  task automatic test_inc_cancel;
    mode_n(4); inc_n(1); mode_n(1);
    tick_n(4);
    n_checks++; if ({ring, H, M, S} !== {1'b1, 5'd0, 6'd2, 6'd0}) begin n_fail++; $display("FAIL ring2_rise: got ring=%b %0d:%0d:%0d required 1 0:2:0", ring, H, M, S); end
    inc_n(1);
    n_checks++; if ({ring, H, M, S, AM} !== {1'b0, 5'd0, 6'd2, 6'd0, 6'd2}) begin n_fail++; $display("FAIL inc_cancel: got ring=%b %0d:%0d:%0d AM=%0d required 0 0:2:0 2", ring, H, M, S, AM); end
    tick_n(4);
    n_checks++; if (ring !== 1'b0) begin n_fail++; $display("FAIL snooze_quiet: got %b required 0", ring); end
    tick_n(1);
`ifdef SNOOZE_EN
    n_checks++; if (ring !== 1'b1) begin n_fail++; $display("FAIL snooze_rering: got %b required 1", ring); end
`else
    n_checks++; if (ring !== 1'b0) begin n_fail++; $display("FAIL no_snooze: got %b required 0", ring); end
`endif
    @(negedge clk) alarm_en = 1'b0;
    @(negedge clk);
    n_checks++; if (ring !== 1'b0) begin n_fail++; $display("FAIL en_cancel: got %b required 0", ring); end
  endtask

  task automatic test_alarm_disabled;
    mode_n(4); inc_n(2); mode_n(1);
    tick_n(4);
    n_checks++; if ({ring, M, S, AM} !== {1'b0, 6'd4, 6'd0, 6'd4}) begin n_fail++; $display("FAIL disabled: got ring=%b M=%0d S=%0d AM=%0d required 0/4/0/4", ring, M, S, AM); end
  endtask

  task automatic test_mode_cancel;
    alarm_en = 1'b1;
    mode_n(4); inc_n(1); mode_n(1);
    tick_n(4);
    n_checks++; if ({ring, M} !== {1'b1, 6'd5}) begin n_fail++; $display("FAIL ring3_rise: got ring=%b M=%0d required 1/5", ring, M); end
    mode_n(1);
    n_checks++; if ({ring, state} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL mode_cancel: got ring=%b st=%0d required 0/1", ring, state); end
    mode_n(3); inc_n(1); mode_n(1);
  endtask

  task automatic test_reset_mid;
    tick_n(4);
    n_checks++; if ({ring, M, AM} !== {1'b1, 6'd6, 6'd6}) begin n_fail++; $display("FAIL ring4_rise: got ring=%b M=%0d AM=%0d required 1/6/6", ring, M, AM); end
    @(negedge clk);
    #2 rst = 1'b1;
    mode_btn = 1'b1;
    #1;
    n_checks++; if ({ring, AH, AM} !== {1'b0, 5'd6, 6'd0}) begin n_fail++; $display("FAIL async_reset: got ring=%b AH=%0d AM=%0d required 0/6/0", ring, AH, AM); end
    n_checks++; if ({H, M, S, state} !== 20'd0) begin n_fail++; $display("FAIL async_reset_time: got %0d:%0d:%0d st=%0d required 0:0:0 0", H, M, S, state); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL held_btn_edge: got st=%0d required 1", state); end
    repeat (3) @(negedge clk);
    mode_btn = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL held_btn_once: got st=%0d required 1", state); end
  endtask

  initial begin
    rst = 1'b1; sec_tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; alarm_en = 1'b0;
    test_reset;
    test_preload_rollover;
    test_set_fields;
    test_alarm_ring;
    test_inc_cancel;
    test_alarm_disabled;
    test_mode_cancel;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
